exec_stage: RTL and testbench
=============================

Name: exec_stage

Overview:
- Execute stage directly downstream of instruction fetch.
- Consumes one decoded op per handshake: opcode, src_a, src_b, dest, imm.
- Holds the 8-entry general register file and the ALU, including a multi-cycle iterative multiplier.
- Drives the chip output port and the condition flags.

Parameters:
- DATA_W, 8, register/immediate/ALU datapath width in bits.
- NREG_BITS, 3, register index width (2**NREG_BITS registers).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- op_valid  input  1  decoded op present this cycle
- op_ready  output  1  stage can accept an op this cycle
- opcode  input  3  operation select (encoding below)
- src_a  input  NREG_BITS  first source register index
- src_b  input  NREG_BITS  second source register index
- dest  input  NREG_BITS  destination register index
- imm  input  DATA_W  immediate operand
- out_data  output  DATA_W  last value emitted by OUT
- out_valid  output  1  one-cycle pulse when out_data updates
- zero_flag  output  1  last ALU/MUL result == 0
- carry_flag  output  1  carry (ADD) or borrow (SUB) of last arithmetic op

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is asynchronous and active-high.
  - On rst: all registers R0..R7 = 0, out_data = 0, out_valid = 0, zero_flag = 0, carry_flag = 0, FSM = IDLE, op_ready = 1 once rst deasserts.
  - rst mid-MUL aborts the multiply; the dest register is not written.
- Handshake:
  - An op is accepted on a rising edge where op_valid && op_ready.
  - op_ready = (state == IDLE), driven combinationally from the FSM state only, never from op_valid.
  - Inputs are ignored when not accepted.
- Opcodes:
  - 0 NOP: no state change.
  - 1 LDI: R[dest] = imm. Flags unchanged.
  - 2 ADD: R[dest] = R[a] + R[b]. carry = bit DATA_W of the sum; zero updated.
  - 3 SUB: R[dest] = R[a] - R[b]. carry = borrow (1 when R[a] < R[b], unsigned); zero updated.
  - 4 AND: R[dest] = R[a] & R[b]. carry = 0; zero updated.
  - 5 XOR: R[dest] = R[a] ^ R[b]. carry = 0; zero updated.
  - 6 MUL: R[dest] = low DATA_W bits of R[a] * R[b], unsigned, multi-cycle (below).
  - 7 OUT: out_data = R[src_a]; out_valid pulses high for exactly the next cycle. Flags unchanged.
- Single-cycle ops (0–5, 7):
  - Result is written at the accepting edge.
  - Register file reads are combinational, so an op accepted on the next cycle sees the new value. Back-to-back dependencies need no stall.
  - dest == src is legal.
- MUL FSM, states IDLE and MUL:
  - IDLE, MUL accepted: latch mcand = R[a], mplier = R[b], acc = 0, cnt = 0, dest_q = dest; go to MUL.
  - MUL, each cycle: if mplier[0], acc += mcand; mcand <<= 1; mplier >>= 1; cnt++.
  - When cnt == DATA_W-1: R[dest_q] = acc_next, zero = (acc_next == 0), carry = 0; go to IDLE.
  - Timing: op_ready is low for exactly DATA_W cycles after the accepting edge. With the default, an op accepted at edge T is written at edge T+8 and op_ready is high in the cycle after edge T+8.
  - Operands are snapshotted at accept, so MUL R3,R3 -> R3 is correct.
- Width rules: all arithmetic is modulo 2**DATA_W. Carry is only observable via carry_flag.
- Simultaneous events:
  - rst has priority over everything.
  - op_valid held high while busy: the op is held off, not dropped; upstream must hold it stable.
  - out_valid is never high two consecutive cycles unless two OUT ops are accepted back-to-back.

Decomposition:
- Shared package exec_pkg:
  - opcode localparams OP_NOP..OP_OUT
  - FSM state encoding ST_IDLE, ST_MUL
  - DATA_W, NREG_BITS defaults
- One natural sub-module: seq_mul, the iterative shift-add multiplier.
  - Interface: start, a, b -> busy, done, product.
  - exec_stage keeps the register file, ALU, flags and handshake.

Test Plan:
- Reset, then check outputs before any op:
  - Assert rst mid-run -> registers and outputs all 0 immediately (asynchronous), op_ready = 1 after release.
  - Then OUT R5 -> out_data = 0x00, out_valid high for 1 cycle.
- ADD carry and back-to-back dependency:
  - LDI R1,0xF0; LDI R2,0x20; ADD R3,R1,R2 -> R3 = 0x10, carry = 1, zero = 0.
  - Then immediately OUT R3 -> out_data = 0x10.
- SUB borrow and zero flag:
  - LDI R1,0x05; SUB R4,R1,R1 -> R4 = 0, zero = 1, carry = 0.
  - SUB R4,R1,R2 with R2 = 0x20 -> R4 = 0xE5, carry = 1.
- MUL timing and operand snapshot:
  - LDI R6,0x0D; MUL R6,R6,R6 -> op_ready low exactly 8 cycles; R6 = 0xA9; carry = 0.
  - An ADD held on op_valid during the MUL is accepted on the first op_ready cycle.
- MUL overflow and abort:
  - 0x10 * 0x10 -> R = 0x00, zero = 1.
  - Start 0x03 * 0x03 into R7 = 0x55, assert rst at cycle 4 -> R7 = 0 (reset value), FSM IDLE, no late write.
- AND/XOR/NOP plus random regression against a reference model:
  - AND 0xCC & 0xAA = 0x88; XOR 0xCC ^ 0xAA = 0x66; NOP changes nothing.
  - 1000 random ops with random op_valid gaps -> register file, flags and out stream all match the model.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: datapath defaults, opcode
// encoding and the multiply FSM state type.
package exec_pkg;

    localparam int DEFAULT_DATA_W    = 8;
    localparam int DEFAULT_NREG_BITS = 3;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_LDI = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_OUT = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/seq_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, W cycles
// per multiply, low W bits of the unsigned product.
module seq_mul
    import exec_pkg::*;
#(
    parameter int W = DEFAULT_DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] product
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

    logic [W-1:0]     mcand;
    logic [W-1:0]     mplier;
    logic [W-1:0]     acc;
    logic [W-1:0]     acc_next;
    logic [CNT_W-1:0] cnt;

    // product is the value acc takes on the final edge, so the consumer can
    // write it on the same edge the multiplier goes idle.
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign product  = acc_next;
    assign done     = busy && (cnt == LAST);

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy   <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (start && !busy) begin
            busy   <= 1'b1;
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
        end else if (busy) begin
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            acc    <= acc_next;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: register file, single-cycle ALU, flags, output port and the
// valid/ready handshake that stalls upstream while a multiply is running.
module exec_stage
    import exec_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int NREG_BITS = DEFAULT_NREG_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [2:0]           opcode,
    input  logic [NREG_BITS-1:0] src_a,
    input  logic [NREG_BITS-1:0] src_b,
    input  logic [NREG_BITS-1:0] dest,
    input  logic [DATA_W-1:0]    imm,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_valid,
    output logic                 zero_flag,
    output logic                 carry_flag
);

    localparam int NREG = 1 << NREG_BITS;

    state_t state, state_next;

    logic [DATA_W-1:0]    rf [NREG];
    logic [DATA_W-1:0]    rd_a, rd_b;
    logic                 accept;
    logic                 mul_start, mul_busy, mul_done;
    logic [DATA_W-1:0]    mul_product;
    logic [NREG_BITS-1:0] dest_q;

    logic [DATA_W-1:0]    alu_res;
    logic                 alu_carry;
    logic                 wr_en;
    logic                 flag_en;

    assign rd_a   = rf[src_a];
    assign rd_b   = rf[src_b];
    assign accept = op_valid && op_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (mul_start) state_next = ST_MUL;
            // !mul_busy keeps the FSM from ever waiting on a multiplier that is not running
            ST_MUL:  if (mul_done || !mul_busy) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        op_ready  = (state == ST_IDLE);
        mul_start = op_ready && op_valid && (opcode == OP_MUL);
    end

    seq_mul #(.W(DATA_W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (rd_a),
        .b       (rd_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        wr_en     = 1'b0;
        flag_en   = 1'b0;
        if (accept) begin
            case (opcode)
                OP_LDI: begin
                    alu_res = imm;
                    wr_en   = 1'b1;
                end
                OP_ADD: begin
                    {alu_carry, alu_res} = {1'b0, rd_a} + {1'b0, rd_b};
                    wr_en   = 1'b1;
                    flag_en = 1'b1;
                end
                OP_SUB: begin
                    // the extra top bit of the wrapped difference is the borrow
                    {alu_carry, alu_res} = {1'b0, rd_a} - {1'b0, rd_b};
                    wr_en   = 1'b1;
                    flag_en = 1'b1;
                end
                OP_AND: begin
                    alu_res = rd_a & rd_b;
                    wr_en   = 1'b1;
                    flag_en = 1'b1;
                end
                OP_XOR: begin
                    alu_res = rd_a ^ rd_b;
                    wr_en   = 1'b1;
                    flag_en = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the register file is small flop storage and must read as zero
    // after reset, so it is cleared here rather than left as a RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                rf[dest] <= alu_res;
            end
            if (mul_done) begin
                rf[dest_q] <= mul_product;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dest_q     <= '0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
        end else begin
            if (mul_start) begin
                dest_q <= dest;
            end
            if (flag_en) begin
                zero_flag  <= (alu_res == '0);
                carry_flag <= alu_carry;
            end else if (mul_done) begin
                zero_flag  <= (mul_product == '0);
                carry_flag <= 1'b0;
            end
            out_valid <= accept && (opcode == OP_OUT);
            if (accept && (opcode == OP_OUT)) begin
                out_data <= rd_a;
            end
        end
    end

endmodule

// File: tb/tb_exec_stage.sv
// Directed and randomized checks of exec_stage: reset, ALU flags, back-to-back
// dependencies, multiply timing/snapshot/abort and a reference-model regression.
module tb_exec_stage;
    import exec_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [2:0] opcode = 3'd0;
    logic [2:0] src_a = 3'd0;
    logic [2:0] src_b = 3'd0;
    logic [2:0] dest = 3'd0;
    logic [7:0] imm = 8'd0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       zero_flag;
    logic       carry_flag;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    exec_stage dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .opcode     (opcode),
        .src_a      (src_a),
        .src_b      (src_b),
        .dest       (dest),
        .imm        (imm),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag)
    );

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic do_op(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] d, input logic [7:0] im);
        int waited = 0;
        opcode = op; src_a = a; src_b = b; dest = d; imm = im;
        op_valid = 1'b1;
        while (!op_ready && waited < 40) begin
            @(posedge clk); @(negedge clk);
            waited++;
        end
        if (!op_ready) begin
            n_checks++;
            $display("FAIL accept_timeout: op_ready=%b after %0d cycles, required 1", op_ready, waited);
            op_valid = 1'b0;
        end else begin
            @(posedge clk); @(negedge clk);
            op_valid = 1'b0;
        end
    endtask

    task automatic wait_ready();
        int waited = 0;
        while (!op_ready && waited < 40) begin
            @(posedge clk); @(negedge clk);
            waited++;
        end
        if (!op_ready) begin
            n_checks++;
            $display("FAIL ready_timeout: op_ready=%b after %0d cycles, required 1", op_ready, waited);
        end
    endtask

    task automatic read_reg(input logic [2:0] idx, output logic [7:0] val, output logic vld);
        do_op(OP_OUT, idx, 3'd0, 3'd0, 8'h00);
        val = out_data;
        vld = out_valid;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        logic       vl;
        repeat (2) @(negedge clk);
        n_checks++; if ({out_data, out_valid, zero_flag, carry_flag} !== 11'd0)
            $display("FAIL reset_outputs: got %h required 000", {out_data, out_valid, zero_flag, carry_flag}); else n_pass++;
        rst = 1'b0;
        n_checks++; if (op_ready !== 1'b1)
            $display("FAIL reset_ready: got %b required 1", op_ready); else n_pass++;
        // dirty some state, then reset asynchronously mid-run
        do_op(OP_LDI, 3'd0, 3'd0, 3'd5, 8'h77);
        do_op(OP_LDI, 3'd0, 3'd0, 3'd1, 8'hF0);
        do_op(OP_LDI, 3'd0, 3'd0, 3'd2, 8'h20);
        do_op(OP_ADD, 3'd1, 3'd2, 3'd3, 8'h00);
        read_reg(3'd5, v, vl);
        n_checks++; if (v !== 8'h77)
            $display("FAIL pre_reset_out: got %h required 77", v); else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_checks++; if ({out_data, carry_flag} !== 9'd0)
            $display("FAIL async_reset: out_data/carry got %h required 000", {out_data, carry_flag}); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (op_ready !== 1'b1)
            $display("FAIL ready_after_release: got %b required 1", op_ready); else n_pass++;
        read_reg(3'd5, v, vl);
        n_checks++; if (v !== 8'h00 || vl !== 1'b1)
            $display("FAIL out_r5_after_reset: data=%h valid=%b required 00/1", v, vl); else n_pass++;
        @(posedge clk); @(negedge clk);
        n_checks++; if (out_valid !== 1'b0)
            $display("FAIL out_valid_pulse: got %b required 0", out_valid); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            read_reg(3'(i), v, vl);
            n_checks++; if (v !== 8'h00)
                $display("FAIL reg_reset_r%0d: got %h required 00", i, v); else n_pass++;
        end
    endtask

    task automatic test_add_carry();
        logic [7:0] v;
        logic       vl;
        do_op(OP_LDI, 3'd0, 3'd0, 3'd1, 8'hF0);
        do_op(OP_LDI, 3'd0, 3'd0, 3'd2, 8'h20);
        do_op(OP_ADD, 3'd1, 3'd2, 3'd3, 8'h00);
        n_checks++; if (carry_flag !== 1'b1 || zero_flag !== 1'b0)
            $display("FAIL add_flags: carry=%b zero=%b required 1/0", carry_flag, zero_flag); else n_pass++;
        read_reg(3'd3, v, vl);
        n_checks++; if (v !== 8'h10 || vl !== 1'b1)
            $display("FAIL add_back_to_back: data=%h valid=%b required 10/1", v, vl); else n_pass++;
    endtask

    task automatic test_sub();
        logic [7:0] v;
        logic       vl;
        do_op(OP_LDI, 3'd0, 3'd0, 3'd1, 8'h05);
        do_op(OP_SUB, 3'd1, 3'd1, 3'd4, 8'h00);
        n_checks++; if (zero_flag !== 1'b1 || carry_flag !== 1'b0)
            $display("FAIL sub_zero_flags: zero=%b carry=%b required 1/0", zero_flag, carry_flag); else n_pass++;
        read_reg(3'd4, v, vl);
        n_checks++; if (v !== 8'h00)
            $display("FAIL sub_zero_value: got %h required 00", v); else n_pass++;
        do_op(OP_SUB, 3'd1, 3'd2, 3'd4, 8'h00);
        n_checks++; if (carry_flag !== 1'b1 || zero_flag !== 1'b0)
            $display("FAIL sub_borrow_flags: carry=%b zero=%b required 1/0", carry_flag, zero_flag); else n_pass++;
        read_reg(3'd4, v, vl);
        n_checks++; if (v !== 8'hE5)
            $display("FAIL sub_borrow_value: got %h required e5", v); else n_pass++;
    endtask

    task automatic test_mul_timing();
        logic [7:0] v;
        logic       vl;
        int         low_cycles = 0;
        do_op(OP_LDI, 3'd0, 3'd0, 3'd6, 8'h0D);
        do_op(OP_MUL, 3'd6, 3'd6, 3'd6, 8'h00);
        // hold an ADD R5 = R6 + R6 on op_valid for the whole multiply
        opcode = OP_ADD; src_a = 3'd6; src_b = 3'd6; dest = 3'd5; imm = 8'h00;
        op_valid = 1'b1;
        while (!op_ready && low_cycles < 40) begin
            low_cycles++;
            @(posedge clk); @(negedge clk);
        end
        n_checks++; if (low_cycles != 8)
            $display("FAIL mul_ready_low: got %0d cycles required 8", low_cycles); else n_pass++;
        n_checks++; if (carry_flag !== 1'b0 || zero_flag !== 1'b0)
            $display("FAIL mul_flags: carry=%b zero=%b required 0/0", carry_flag, zero_flag); else n_pass++;
        @(posedge clk); @(negedge clk);
        op_valid = 1'b0;
        n_checks++; if (carry_flag !== 1'b1 || zero_flag !== 1'b0)
            $display("FAIL held_add_flags: carry=%b zero=%b required 1/0", carry_flag, zero_flag); else n_pass++;
        read_reg(3'd6, v, vl);
        n_checks++; if (v !== 8'hA9)
            $display("FAIL mul_square: got %h required a9", v); else n_pass++;
        read_reg(3'd5, v, vl);
        n_checks++; if (v !== 8'h52)
            $display("FAIL held_add_value: got %h required 52", v); else n_pass++;
    endtask

    task automatic test_mul_overflow_abort();
        logic [7:0] v;
        logic       vl;
        do_op(OP_LDI, 3'd0, 3'd0, 3'd1, 8'h10);
        do_op(OP_MUL, 3'd1, 3'd1, 3'd2, 8'h00);
        wait_ready();
        n_checks++; if (zero_flag !== 1'b1 || carry_flag !== 1'b0)
            $display("FAIL mul_overflow_flags: zero=%b carry=%b required 1/0", zero_flag, carry_flag); else n_pass++;
        read_reg(3'd2, v, vl);
        n_checks++; if (v !== 8'h00)
            $display("FAIL mul_overflow_value: got %h required 00", v); else n_pass++;
        do_op(OP_LDI, 3'd0, 3'd0, 3'd7, 8'h55);
        do_op(OP_LDI, 3'd0, 3'd0, 3'd3, 8'h03);
        do_op(OP_MUL, 3'd3, 3'd3, 3'd7, 8'h00);
        repeat (3) begin
            @(posedge clk); @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (op_ready !== 1'b1)
            $display("FAIL abort_ready: got %b required 1", op_ready); else n_pass++;
        repeat (10) begin
            @(posedge clk); @(negedge clk);
        end
        read_reg(3'd7, v, vl);
        n_checks++; if (v !== 8'h00)
            $display("FAIL abort_no_write: got %h required 00", v); else n_pass++;
        n_checks++; if (zero_flag !== 1'b0)
            $display("FAIL abort_zero_flag: got %b required 0", zero_flag); else n_pass++;
    endtask

    task automatic test_logic_nop();
        logic [7:0] v;
        logic       vl;
        do_op(OP_LDI, 3'd0, 3'd0, 3'd1, 8'hCC);
        do_op(OP_LDI, 3'd0, 3'd0, 3'd2, 8'hAA);
        do_op(OP_SUB, 3'd2, 3'd1, 3'd4, 8'h00);
        n_checks++; if (carry_flag !== 1'b1)
            $display("FAIL sub_aa_cc_borrow: got %b required 1", carry_flag); else n_pass++;
        do_op(OP_AND, 3'd1, 3'd2, 3'd3, 8'h00);
        n_checks++; if (carry_flag !== 1'b0 || zero_flag !== 1'b0)
            $display("FAIL and_flags: carry=%b zero=%b required 0/0", carry_flag, zero_flag); else n_pass++;
        read_reg(3'd3, v, vl);
        n_checks++; if (v !== 8'h88)
            $display("FAIL and_value: got %h required 88", v); else n_pass++;
        do_op(OP_XOR, 3'd1, 3'd2, 3'd4, 8'h00);
        read_reg(3'd4, v, vl);
        n_checks++; if (v !== 8'h66)
            $display("FAIL xor_value: got %h required 66", v); else n_pass++;
        do_op(OP_SUB, 3'd1, 3'd1, 3'd5, 8'h00);
        do_op(OP_NOP, 3'd1, 3'd2, 3'd3, 8'hFF);
        n_checks++; if (zero_flag !== 1'b1 || carry_flag !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL nop_flags: zero=%b carry=%b out_valid=%b required 1/0/0", zero_flag, carry_flag, out_valid); else n_pass++;
        read_reg(3'd3, v, vl);
        n_checks++; if (v !== 8'h88)
            $display("FAIL nop_no_write: got %h required 88", v); else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] m_rf [8];
        logic       m_zero, m_carry;
        logic [7:0] v;
        logic       vl;
        logic [2:0] op, a, b, d;
        logic [7:0] im;
        int         ra, rb, r;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
        m_zero = 1'b0;
        m_carry = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 2)) begin
                opcode = 3'($urandom); dest = 3'($urandom); imm = 8'($urandom);
                @(posedge clk); @(negedge clk);
                n_checks++; if (out_valid !== 1'b0)
                    $display("FAIL rnd_gap_out_valid[%0d]: got %b required 0", n, out_valid); else n_pass++;
            end
            op = 3'($urandom); a = 3'($urandom); b = 3'($urandom);
            d = 3'($urandom);  im = 8'($urandom);
            ra = int'(m_rf[a]);
            rb = int'(m_rf[b]);
            r  = -1;
            case (op)
                OP_LDI: m_rf[d] = im;
                OP_ADD: begin r = (ra + rb) % 256; m_carry = (ra + rb) > 255; end
                OP_SUB: begin r = (ra - rb + 256) % 256; m_carry = (ra < rb); end
                OP_AND: begin r = int'(m_rf[a] & m_rf[b]); m_carry = 1'b0; end
                OP_XOR: begin r = int'(m_rf[a] ^ m_rf[b]); m_carry = 1'b0; end
                OP_MUL: begin r = (ra * rb) % 256; m_carry = 1'b0; end
                default: ;
            endcase
            if (r >= 0) begin
                m_rf[d] = 8'(r);
                m_zero  = (r == 0);
            end
            do_op(op, a, b, d, im);
            if (op == OP_MUL) wait_ready();
            n_checks++; if (zero_flag !== m_zero || carry_flag !== m_carry)
                $display("FAIL rnd_flags[%0d] op=%0d: zero=%b carry=%b required %b/%b", n, op, zero_flag, carry_flag, m_zero, m_carry); else n_pass++;
            if (op == OP_OUT) begin
                n_checks++; if (out_valid !== 1'b1 || out_data !== m_rf[a])
                    $display("FAIL rnd_out[%0d]: data=%h valid=%b required %h/1", n, out_data, out_valid, m_rf[a]); else n_pass++;
            end
        end
        for (int i = 0; i < 8; i++) begin
            read_reg(3'(i), v, vl);
            n_checks++; if (v !== m_rf[i])
                $display("FAIL rnd_final_r%0d: got %h required %h", i, v, m_rf[i]); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_add_carry();
        test_sub();
        test_mul_timing();
        test_mul_overflow_abort();
        test_logic_nop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
